// File: rtl/sync_fifo_wr_arb_if.sv
// Bundle of the requester-side handshake and FIFO write/occupancy signals
// shared by the write arbiter and its environment.
// master: producers and FIFO (drive requests, occupancy and full flag)
// slave : the arbiter (drives acks, grants and the FIFO write port)
interface sync_fifo_wr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int CNT_W   = 5
) ();
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    grant;
  logic [CNT_W-1:0]      fifo_flag_counter;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DW-1:0]         fifo_wr_data;

  modport master (
    output req, req_data, req_last, fifo_flag_counter, fifo_full,
    input  ack, grant, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req, req_data, req_last, fifo_flag_counter, fifo_full,
    output ack, grant, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter sharing one synchronous FIFO between NUM_REQ
// producers. Grants bounded bursts, registers the FIFO write strobe/data and
// tracks free space from the occupancy count plus the write still in flight.
// Optional macro SYNC_FIFO_WR_ARB_WATERMARK_EN: only grant a burst when
// MAX_BURST entries are free, so a granted burst never stalls for space.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner, waiting for any request while enabled
// S_ARB   | one cycle to pick the next owner from rr_ptr (or wait)
// S_BURST | owner holds grant, beats accepted while space allows
module sync_fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 5,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_en,
  sync_fifo_wr_arb_if.slave      bus,
  output logic                   busy,
  output logic [ID_W-1:0]        cur_id
);

  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W:0]    L_DEPTH     = (CNT_W+1)'(DEPTH);
  localparam logic [BCW-1:0]    L_LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   L_LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_BURST} state_t;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_wr_en;
  logic [DW-1:0]         r_wr_data;
  logic [ID_W-1:0]       r_cur_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [BCW-1:0]        r_beat_cnt;

  logic [CNT_W:0]        w_space;
  logic                  w_can_wr;
  logic                  w_arb_ok;
  logic [NUM_REQ-1:0]    w_ack;
  logic                  w_any_ack;
  logic                  w_g_req;
  logic                  w_g_last;
  logic [DW-1:0]         w_g_data;
  logic                  w_found;
  logic [ID_W-1:0]       w_win;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_rr_next;

  // Free entries, counting the write registered last cycle that the
  // occupancy count has not seen yet; MSB set means the result went negative.
  assign w_space  = L_DEPTH - {1'b0, bus.fifo_flag_counter} - {{CNT_W{1'b0}}, r_wr_en};
  assign w_can_wr = ~w_space[CNT_W] & (w_space != '0) & ~bus.fifo_full;

`ifdef SYNC_FIFO_WR_ARB_WATERMARK_EN
  localparam logic [CNT_W:0] L_MAX_BURST = (CNT_W+1)'(MAX_BURST);
  assign w_arb_ok = ~w_space[CNT_W] & (w_space >= L_MAX_BURST);
`else
  assign w_arb_ok = 1'b1;
`endif

  assign w_g_req  = |(r_grant & bus.req);
  assign w_g_last = |(r_grant & bus.req_last);

  // Disabling the FIFO kills acceptance in the same cycle.
  assign w_ack     = (r_state == S_BURST && fifo_en) ?
                     (r_grant & bus.req & {NUM_REQ{w_can_wr}}) : '0;
  assign w_any_ack = |w_ack;

  // Data of the current owner, selected by the one-hot grant.
  always_comb begin
    w_g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_g_data = bus.req_data[i*DW +: DW];
    end
  end

  // First active request scanning upward from rr_ptr with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(r_rr_ptr) + i >= NUM_REQ) ? ID_W'(int'(r_rr_ptr) + i - NUM_REQ)
                                              : ID_W'(int'(r_rr_ptr) + i);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_rr_next = (w_win == L_LAST_ID) ? '0 : w_win + 1'b1;

  // Arbitration/burst FSM with registered grant and FIFO write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_cur_id   <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else if (!fifo_en) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_wr_en    <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_wr_en <= w_any_ack;
      if (w_any_ack) r_wr_data <= w_g_data;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (!w_found) begin
            r_state <= S_IDLE;
          end else if (w_arb_ok) begin
            r_grant    <= NUM_REQ'(1) << w_win;
            r_cur_id   <= w_win;
            r_rr_ptr   <= w_rr_next;
            r_beat_cnt <= '0;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_any_ack) begin
            r_beat_cnt <= r_beat_cnt + BCW'(1);
            if (w_g_last || r_beat_cnt == L_LAST_BEAT) begin
              r_grant <= '0;
              r_state <= S_ARB;
            end
          end else if (!w_g_req) begin
            // Owner withdrew; a stall for space alone keeps the grant.
            r_grant <= '0;
            r_state <= S_ARB;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack          = w_ack;
  assign bus.grant        = r_grant;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_wr_data = r_wr_data;
  assign busy             = (r_state != S_IDLE);
  assign cur_id           = r_cur_id;

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: requester queues, an occupancy model of the
// FIFO and a write-data scoreboard filled in expected write order.
module tb_sync_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int CW = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_en = 1'b0;
  logic       busy;
  logic [1:0] cur_id;

  sync_fifo_wr_arb_if #(.NUM_REQ(NR), .DW(DW), .CNT_W(CW)) bus_if ();

  sync_fifo_wr_arb #(.NUM_REQ(NR), .DW(DW), .DEPTH(16), .CNT_W(CW), .MAX_BURST(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fifo_en (fifo_en),
    .bus     (bus_if.slave),
    .busy    (busy),
    .cur_id  (cur_id)
  );

  always #5 clk = ~clk;

  logic [16:0]   rq [NR][$];
  logic [15:0]   exp_q[$];
  logic [NR-1:0] glog[$];
  logic [NR-1:0] en_mask;
  logic [4:0]    fcnt;
  logic          rd_pulse;
  logic [NR-1:0] s_ack, s_grant, s_req, prev_grant;
  logic          s_wr, s_busy;
  logic [15:0]   s_data;
  logic [1:0]    s_cur;
  int n_vec = 0, n_err = 0;
  int n_ack, n_wr, n_ovf = 0, cyc_n, g_first, g_last;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, want);
    end
  endtask

  task automatic drive();
    logic [NR-1:0]    r_v, l_v;
    logic [NR*DW-1:0] d_v;
    logic [16:0]      b;
    r_v = '0; l_v = '0; d_v = '0;
    for (int i = 0; i < NR; i++) begin
      if (en_mask[i] && rq[i].size() > 0) begin
        b   = rq[i][0];
        r_v = r_v | (NR'(1) << i);
        l_v = l_v | (NR'(b[16]) << i);
        d_v = d_v | ((NR*DW)'(b[15:0]) << (i*DW));
      end
    end
    bus_if.req               = r_v;
    bus_if.req_last          = l_v;
    bus_if.req_data          = d_v;
    bus_if.fifo_flag_counter = fcnt;
    bus_if.fifo_full         = (fcnt >= 5'd16);
  endtask

  task automatic add_beat(input int r, input logic [15:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  // One clock: sample at negedge, score writes, then update models after posedge.
  task automatic cyc();
    logic [15:0] w;
    @(negedge clk);
    s_ack = bus_if.ack; s_grant = bus_if.grant; s_req = bus_if.req;
    s_wr = bus_if.fifo_wr_en; s_data = bus_if.fifo_wr_data;
    s_busy = busy; s_cur = cur_id;
    cyc_n++;
    n_ack += $countones(s_ack);
    n_wr  += int'(s_wr);
    if (s_wr) begin
      if (fcnt >= 5'd16) n_ovf++;
      if (exp_q.size() == 0) check_val("sb_extra_wr", 32'(s_data), 32'h1_0000);
      else begin
        w = exp_q.pop_front();
        check_val("wr_data", 32'(s_data), 32'(w));
      end
    end
    if (s_grant != 0 && prev_grant == 0) glog.push_back(s_grant);
    prev_grant = s_grant;
    if (s_grant != 0) begin
      if (g_first < 0) g_first = cyc_n;
      g_last = cyc_n;
    end
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++)
      if (s_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    fcnt = fcnt + 5'(s_wr) - 5'(rd_pulse);
    rd_pulse = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete(); glog.delete();
    fcnt = '0; rd_pulse = 1'b0; en_mask = '1; fifo_en = 1'b1;
    n_ack = 0; n_wr = 0; cyc_n = 0; g_first = -1; g_last = -1; prev_grant = '0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    bit done;
    done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      cyc();
      if (!s_busy && s_req == 0) done = 1'b1;
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_acks(input string tag, input int target, input int bound);
    for (int k = 0; k < bound && n_ack < target; k++) cyc();
    check_val(tag, 32'(n_ack >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] g_exp [5];
    int t3_acks;
    logic [NR-1:0] t3_grant;

    // ---- T1: reset state, then single requester, 3-beat packet
    do_reset();
    add_beat(0, 16'h1111, 1'b0); add_beat(0, 16'h2222, 1'b0); add_beat(0, 16'h3333, 1'b1);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
    drive();
    cyc();
    check_val("rst_grant", 32'(s_grant), 32'd0);
    check_val("rst_ack", 32'(s_ack), 32'd0);
    check_val("rst_wr_en", 32'(s_wr), 32'd0);
    check_val("rst_wr_data", 32'(s_data), 32'd0);
    check_val("rst_busy", 32'(s_busy), 32'd0);
    check_val("rst_cur_id", 32'(s_cur), 32'd0);
    cyc();
    check_val("t1_arb_busy", 32'(s_busy), 32'd1);
    check_val("t1_arb_grant", 32'(s_grant), 32'd0);
    cyc();
    check_val("t1_b1_ack", 32'(s_ack), 32'b0001);
    check_val("t1_b1_wr", 32'(s_wr), 32'd0);
    cyc();
    check_val("t1_b2_ack", 32'(s_ack), 32'b0001);
    check_val("t1_b2_wr", 32'(s_wr), 32'd1);
    cyc();
    check_val("t1_b3_ack", 32'(s_ack), 32'b0001);
    check_val("t1_b3_wr", 32'(s_wr), 32'd1);
    cyc();
    check_val("t1_end_grant", 32'(s_grant), 32'd0);
    check_val("t1_end_wr", 32'(s_wr), 32'd1);
    check_val("t1_end_busy", 32'(s_busy), 32'd1);
    cyc();
    check_val("t1_idle_busy", 32'(s_busy), 32'd0);
    check_val("t1_idle_wr", 32'(s_wr), 32'd0);
    check_val("t1_cur_id", 32'(s_cur), 32'd0);
    check_val("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // ---- T2: all four requesting, 2-beat packets, order 0,1,2,3,0
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 2; b++) add_beat(0, 16'hA000 | 16'(p << 4) | 16'(b), b == 1);
    for (int r = 1; r < NR; r++)
      for (int b = 0; b < 2; b++) add_beat(r, 16'hA000 | 16'(r << 8) | 16'(b), b == 1);
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < 2; b++) exp_q.push_back(16'hA000 | 16'(r << 8) | 16'(b));
    for (int b = 0; b < 2; b++) exp_q.push_back(16'hA010 | 16'(b));
    drive();
    run_until_idle("t2_idle_timeout", 60);
    g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check_val("t2_grant_count", 32'(glog.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check_val("t2_grant_order", (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'(g_exp[k]));
    check_val("t2_span", 32'(g_last - g_first + 1), 32'd14);
    check_val("t2_writes", 32'(n_wr), 32'd10);
    check_val("t2_sb_drained", 32'(exp_q.size()), 32'd0);

    // ---- T3: one requester streams 20 beats, FIFO never read
`ifdef SYNC_FIFO_WR_ARB_WATERMARK_EN
    t3_acks = 16; t3_grant = 4'b0000;
`else
    t3_acks = 17; t3_grant = 4'b0001;
`endif
    do_reset();
    for (int b = 0; b < 20; b++) add_beat(0, 16'hC000 | 16'(b), 1'b0);
    for (int b = 0; b < t3_acks; b++) exp_q.push_back(16'hC000 | 16'(b));
    drive();
    repeat (40) cyc();
    check_val("t3_acks_full", 32'(n_ack), 32'd16);
    check_val("t3_writes_full", 32'(n_wr), 32'd16);
    check_val("t3_ack_stalled", 32'(s_ack), 32'd0);
    check_val("t3_grant_held", 32'(s_grant), 32'(t3_grant));
    check_val("t3_fifo_count", 32'(fcnt), 32'd16);
    rd_pulse = 1'b1;
    repeat (10) cyc();
    check_val("t3_acks_after_read", 32'(n_ack), 32'(t3_acks));
    check_val("t3_sb_drained", 32'(exp_q.size()), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_grant", 32'(bus_if.grant), 32'd0);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    check_val("async_rst_wr_en", 32'(bus_if.fifo_wr_en), 32'd0);

    // ---- T4: req[2] withdraws after 2 beats, req[3] wins next
    do_reset();
    for (int b = 1; b <= 3; b++) add_beat(2, 16'hD200 | 16'(b), 1'b0);
    add_beat(3, 16'hD301, 1'b0); add_beat(3, 16'hD302, 1'b1);
    exp_q.push_back(16'hD201); exp_q.push_back(16'hD202);
    exp_q.push_back(16'hD301); exp_q.push_back(16'hD302);
    drive();
    wait_acks("t4_ack_timeout", 2, 20);
    en_mask[2] = 1'b0;
    drive();
    cyc();
    check_val("t4_drop_grant", 32'(s_grant), 32'b0100);
    check_val("t4_drop_ack", 32'(s_ack), 32'd0);
    cyc();
    check_val("t4_rearb_grant", 32'(s_grant), 32'd0);
    check_val("t4_rearb_busy", 32'(s_busy), 32'd1);
    cyc();
    check_val("t4_next_grant", 32'(s_grant), 32'b1000);
    check_val("t4_next_ack", 32'(s_ack), 32'b1000);
    check_val("t4_cur_id", 32'(s_cur), 32'd3);
    run_until_idle("t4_idle_timeout", 20);
    check_val("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // ---- T5: fifo_en low during the 2nd beat, then resume from rr_ptr
    do_reset();
    for (int b = 1; b <= 4; b++) add_beat(0, 16'h5000 | 16'(b), b == 4);
    exp_q.push_back(16'h5001); exp_q.push_back(16'h6001);
    exp_q.push_back(16'h5002); exp_q.push_back(16'h5003); exp_q.push_back(16'h5004);
    drive();
    wait_acks("t5_ack_timeout", 1, 20);
    fifo_en = 1'b0;
    cyc();
    check_val("t5_flush_ack", 32'(s_ack), 32'd0);
    add_beat(1, 16'h6001, 1'b1);
    fifo_en = 1'b1;
    drive();
    cyc();
    check_val("t5_flush_grant", 32'(s_grant), 32'd0);
    check_val("t5_flush_wr", 32'(s_wr), 32'd0);
    check_val("t5_flush_busy", 32'(s_busy), 32'd0);
    check_val("t5_cur_id_kept", 32'(s_cur), 32'd0);
    cyc();
    check_val("t5_arb_grant", 32'(s_grant), 32'd0);
    cyc();
    check_val("t5_resume_grant", 32'(s_grant), 32'b0010);
    check_val("t5_resume_ack", 32'(s_ack), 32'b0010);
    run_until_idle("t5_idle_timeout", 30);
    check_val("t5_sb_drained", 32'(exp_q.size()), 32'd0);

    // ---- T6: start with 13 entries occupied, 4-beat packet on req[0]
    do_reset();
    fcnt = 5'd13;
    for (int b = 1; b <= 4; b++) begin
      add_beat(0, 16'h7000 | 16'(b), b == 4);
      exp_q.push_back(16'h7000 | 16'(b));
    end
    drive();
`ifdef SYNC_FIFO_WR_ARB_WATERMARK_EN
    repeat (8) cyc();
    check_val("t6_wm_no_ack", 32'(n_ack), 32'd0);
    check_val("t6_wm_no_grant", 32'(s_grant), 32'd0);
    check_val("t6_wm_busy", 32'(s_busy), 32'd1);
    fcnt = 5'd12;
    drive();
    cyc();
    check_val("t6_wm_arb", 32'(s_grant), 32'd0);
    for (int b = 0; b < 4; b++) begin
      cyc();
      check_val("t6_wm_beat", 32'(s_ack), 32'b0001);
    end
    run_until_idle("t6_idle_timeout", 20);
`else
    repeat (12) cyc();
    check_val("t6_stall_acks", 32'(n_ack), 32'd3);
    check_val("t6_stall_grant", 32'(s_grant), 32'b0001);
    rd_pulse = 1'b1;
    run_until_idle("t6_idle_timeout", 20);
    check_val("t6_total_acks", 32'(n_ack), 32'd4);
`endif
    check_val("t6_fifo_count", 32'(fcnt), 32'd16);
    check_val("t6_sb_drained", 32'(exp_q.size()), 32'd0);
    check_val("no_overflow", 32'(n_ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
